// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: default frame geometry (also used by the
// transmitter), receiver state encoding and small elaboration helpers.
// Build macro: UART_RX_PARITY_EN widens the state encoding to 3 bits and
// adds ST_PARITY.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  // Larger of two integers, used to size counters at elaboration time.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input bit.
// Ports:
//   i_clk      destination clock
//   i_reset_n  asynchronous active-low reset (both flops load RESET_VAL)
//   i_d        asynchronous input
//   o_q        synchronised output, two i_clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_r;
  logic sync_r;

  // Metastability chain: first flop may go metastable, second settles it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= i_d;
      sync_r <= meta_r;
    end
  end

  assign o_q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver driven by a 16x oversampling baud tick. Detects the start
// edge, confirms it at mid start bit, samples each data bit (LSB first) at
// mid-bit, checks the stop bit and presents the word with a one-clock done
// pulse.
// Ports:
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset
//   i_baud_tick  one-clock pulse at OVERSAMPLE x baud rate
//   i_rx         serial line, idle high, asynchronous to i_clk
//   o_data       last received word (held until the next frame completes)
//   o_rx_done    one-clock pulse when a frame completes
//   o_frame_err  stop bit was sampled low on the last frame
//   o_parity_err even-parity mismatch on the last frame (UART_RX_PARITY_EN)
// Build macro: UART_RX_PARITY_EN inserts a parity bit between data and stop.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_baud_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_parity_err
`endif
);

  localparam int TICK_W = max_int(max_int($clog2(OVERSAMPLE), $clog2(STOP_TICKS)), 1);
  localparam int BIT_W  = max_int($clog2(DATA_BITS), 1);

  localparam logic [TICK_W-1:0] TICK_ZERO  = TICK_W'(32'd0);
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(32'd1);
  localparam logic [TICK_W-1:0] START_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_TLAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST  = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO   = BIT_W'(32'd0);
  localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(32'd1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state_r,     state_nxt_s;
  logic [TICK_W-1:0]    tick_cnt_r,  tick_cnt_nxt_s;
  logic [BIT_W-1:0]     bit_cnt_r,   bit_cnt_nxt_s;
  logic [DATA_BITS-1:0] shift_r,     shift_nxt_s;
  logic [DATA_BITS-1:0] data_r,      data_nxt_s;
  logic                 done_r,      done_nxt_s;
  logic                 frame_err_r, frame_err_nxt_s;
`ifdef UART_RX_PARITY_EN
  logic                 parity_r,     parity_nxt_s;
  logic                 parity_err_r, parity_err_nxt_s;

  // Even parity: the data bits plus the parity bit must XOR to zero.
  function automatic logic even_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction
`endif

  // Line reads idle (1) while in reset so no false start is seen on release.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_rx),
    .o_q       (rx_s)
  );

  // Next-state and datapath: counters advance only on baud ticks.
  always_comb begin
    state_nxt_s     = state_r;
    tick_cnt_nxt_s  = tick_cnt_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    shift_nxt_s     = shift_r;
    data_nxt_s      = data_r;
    done_nxt_s      = 1'b0;
    frame_err_nxt_s = frame_err_r;
`ifdef UART_RX_PARITY_EN
    parity_nxt_s     = parity_r;
    parity_err_nxt_s = parity_err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // Leaving idle is edge driven; the tick phase is irrelevant here.
        if (!rx_s) begin
          state_nxt_s    = ST_START;
          tick_cnt_nxt_s = TICK_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (i_baud_tick) begin
          if (tick_cnt_r == START_LAST) begin
            // Mid start bit: still low means a real start, else a glitch.
            if (!rx_s) begin
              state_nxt_s    = ST_DATA;
              tick_cnt_nxt_s = TICK_ZERO;
              bit_cnt_nxt_s  = BIT_ZERO;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (i_baud_tick) begin
          if (tick_cnt_r == BIT_TLAST) begin
            shift_nxt_s    = {rx_s, shift_r[DATA_BITS-1:1]};
            tick_cnt_nxt_s = TICK_ZERO;
            if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt_s = ST_PARITY;
`else
              state_nxt_s = ST_STOP;
`endif
            end else begin
              bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
            end
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (i_baud_tick) begin
          if (tick_cnt_r == BIT_TLAST) begin
            parity_nxt_s   = rx_s;
            tick_cnt_nxt_s = TICK_ZERO;
            state_nxt_s    = ST_STOP;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
          end
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (i_baud_tick) begin
          if (tick_cnt_r == STOP_LAST) begin
            // A bad stop bit still publishes the word, flagged by frame_err.
            data_nxt_s      = shift_r;
            frame_err_nxt_s = ~rx_s;
            done_nxt_s      = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_nxt_s = even_parity_err(shift_r, parity_r);
`endif
            state_nxt_s     = ST_IDLE;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        tick_cnt_nxt_s = TICK_ZERO;
        bit_cnt_nxt_s  = BIT_ZERO;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      tick_cnt_r  <= TICK_ZERO;
      bit_cnt_r   <= BIT_ZERO;
      shift_r     <= {DATA_BITS{1'b0}};
      data_r      <= {DATA_BITS{1'b0}};
      done_r      <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_r     <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      tick_cnt_r  <= tick_cnt_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      data_r      <= data_nxt_s;
      done_r      <= done_nxt_s;
      frame_err_r <= frame_err_nxt_s;
`ifdef UART_RX_PARITY_EN
      parity_r     <= parity_nxt_s;
      parity_err_r <= parity_err_nxt_s;
`endif
    end
  end

  assign o_data      = data_r;
  assign o_rx_done   = done_r;
  assign o_frame_err = frame_err_r;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx: the stimulus thread pushes the expected word
// and error flags for every frame it sends; a monitor pops and compares on
// each o_rx_done pulse. The baud divider is shorter than a 100 MHz / 19600
// generator (318 clocks per tick) to keep the run brief; the receiver only
// sees ticks, so its behaviour is the same.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int STOP_T   = 16;
  localparam int TICK_DIV = 20;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_baud_tick = 1'b0;
  logic          i_rx = 1'b1;
  logic [DB-1:0] o_data;
  logic          o_rx_done;
  logic          o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic          o_parity_err;
`endif

  typedef struct packed {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   done_seen = 0;
  int   frames_sent = 0;
  int   div_cnt = 0;
  logic prev_done = 1'b0;

  uart_rx #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .STOP_TICKS (STOP_T)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_baud_tick  (i_baud_tick),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_rx_done    (o_rx_done),
    .o_frame_err  (o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err (o_parity_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Baud generator: one-clock tick every TICK_DIV clocks.
  always @(posedge i_clk) begin
    if (div_cnt == TICK_DIV - 1) begin
      div_cnt     <= 0;
      i_baud_tick <= 1'b1;
    end else begin
      div_cnt     <= div_cnt + 1;
      i_baud_tick <= 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge i_clk);
  endtask

  // Serialise one frame; stop_ticks lets a low stop bit end early so the
  // receiver does not read the tail of it as a new start bit.
  task automatic send_raw(input logic [DB-1:0] d, input logic par_bit,
                          input logic stop_bit, input int stop_ticks);
    i_rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      i_rx = d[i];
      wait_ticks(OS);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = par_bit;
    wait_ticks(OS);
`endif
    i_rx = stop_bit;
    wait_ticks(stop_ticks);
    i_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par_bit,
                            input logic stop_bit, input logic exp_perr);
    exp_t e;
    e.data = d;
    e.ferr = ~stop_bit;
    e.perr = exp_perr;
    exp_q.push_back(e);
    frames_sent++;
    send_raw(d, par_bit, stop_bit, stop_bit ? STOP_T : (OS * 3) / 4);
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (prev_done) check("done_one_cycle", int'(o_rx_done), 0);
      prev_done = o_rx_done;
      if (o_rx_done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got data 0x%0h, expected no pulse", o_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", int'(o_data), int'(e.data));
          check("frame_err", int'(o_frame_err), int'(e.ferr));
`ifdef UART_RX_PARITY_EN
          check("parity_err", int'(o_parity_err), int'(e.perr));
`endif
        end
      end
    end
  end

  initial begin
    // Reset values.
    repeat (4) @(negedge i_clk);
    check("reset_data", int'(o_data), 0);
    check("reset_done", int'(o_rx_done), 0);
    check("reset_ferr", int'(o_frame_err), 0);
`ifdef UART_RX_PARITY_EN
    check("reset_perr", int'(o_parity_err), 0);
`endif
    i_reset_n = 1'b1;
    wait_ticks(2 * OS);

    // Good frame, then a frame with its stop bit low.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    wait_ticks(2 * OS);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_ticks(2 * OS);

    // Short low glitch: rejected at mid start bit, output untouched.
    i_rx = 1'b0;
    wait_ticks(5);
    i_rx = 1'b1;
    wait_ticks(2 * OS);
    check("glitch_data_hold", int'(o_data), 32'h3C);
    check("glitch_ferr_hold", int'(o_frame_err), 1);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    wait_ticks(2 * OS);

    // Reset during data bit 4 of 0x5A: no pulse, outputs cleared.
    i_rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      i_rx = 1'(8'h5A >> i);
      wait_ticks(OS);
    end
    i_rx = 1'b1;
    wait_ticks(OS / 2);
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("midreset_data", int'(o_data), 0);
    check("midreset_ferr", int'(o_frame_err), 0);
    i_reset_n = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    wait_ticks(2 * OS);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 1 is even, parity bit 0 is not.
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_ticks(2 * OS);
    send_frame(8'h07, 1'b0, 1'b1, 1'b1);
    wait_ticks(2 * OS);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    check("done_pulse_count", done_seen, frames_sent);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
